// File: rtl/and_unit.sv
// and_unit -- bitwise AND datapath element for the ALU.
//
// F is a purely combinational A & B. A registered copy of the result, with
// a valid strobe and zero/all-ones status flags, is provided for pipelined
// consumers in the ALU result path.
//
// Parameters:
//   WIDTH      operand and result width in bits (1..64)
//
// Ports:
//   clk        rising-edge clock for the registered path
//   rst        asynchronous, active-high reset for all registers
//   A, B       operands
//   in_valid   qualifies A/B for the registered path
//   F          combinational A & B
//   F_q        registered A & B
//   out_valid  F_q, zero_q and ones_q hold a valid result
//   zero_q     registered flag: result equals 0
//   ones_q     registered flag: result is all ones
module and_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q
);

  // Combinational result; X on an operand bit only reaches that result bit.
  assign F = A & B;

  // Result, flags and valid are captured together. When no new operand pair
  // is presented, only out_valid drops; the last result and flags are held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_q       <= '0;
      out_valid <= 1'b0;
      zero_q    <= 1'b0;
      ones_q    <= 1'b0;
    end else if (in_valid) begin
      F_q       <= F;
      out_valid <= 1'b1;
      zero_q    <= (F == '0);
      ones_q    <= (F == '1);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_and_unit.sv
module tb_and_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, b, f, f_q;
  logic        in_valid, out_valid, zero_q, ones_q;

  logic [15:0] a16, b16, f16, f_q16;
  logic        in_valid16, out_valid16, zero_q16, ones_q16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  and_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .in_valid(in_valid),
    .F(f), .F_q(f_q), .out_valid(out_valid), .zero_q(zero_q), .ones_q(ones_q)
  );

  and_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .in_valid(in_valid16),
    .F(f16), .F_q(f_q16), .out_valid(out_valid16), .zero_q(zero_q16),
    .ones_q(ones_q16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       vld;
    logic [7:0] exp_f;
    logic [7:0] exp_fq;
    logic       exp_ov;
    logic       exp_z;
    logic       exp_o;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] fq, input logic ov,
                          input logic z, input logic o);
    chk({tag, ".F_q"}, 64'(f_q), 64'(fq));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, ".zero_q"}, 64'(zero_q), 64'(z));
    chk({tag, ".ones_q"}, 64'(ones_q), 64'(o));
  endtask

  initial begin
    //            a      b      vld   F      F_q    ov    z     o
    vecs[0] = '{8'h01, 8'h01, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h7B, 1'b1, 8'h7B, 8'h7B, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h87, 8'h0A, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 8'hC3, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'h7B, 1'b1, 8'h7B, 8'h7B, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h10, 8'h7B, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{8'hAA, 8'h55, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; a = 8'h00; b = 8'h00; in_valid = 1'b0;
    a16 = '0; b16 = '0; in_valid16 = 1'b0;

    // Reset state, and F live during reset.
    @(posedge clk); #1;
    chk_regs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    a = 8'h01; b = 8'h01; #1;
    chk("reset.F", 64'(f), 64'h01);

    @(negedge clk); rst = 1'b0;

    // Table: drive at negedge, F checked 1 ns later, registers after the edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; in_valid = vecs[i].vld;
      #1;
      chk($sformatf("vec%0d.F", i), 64'(f), 64'(vecs[i].exp_f));
      @(posedge clk); #1;
      chk_regs($sformatf("vec%0d", i), vecs[i].exp_fq, vecs[i].exp_ov,
               vecs[i].exp_z, vecs[i].exp_o);
    end

    // X on a bit whose partner is 0 yields 0.
    @(negedge clk);
    in_valid = 1'b0; a = {4'hx, 4'h5}; b = 8'h0F; #1;
    chk("xmask.F", 64'(f), 64'h05);

    // Async reset between edges while out_valid=1.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_regs("pre_rst", 8'hFF, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1; #1;
    chk_regs("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    a = 8'h0F; b = 8'hF3; #1;
    chk("async_rst.F", 64'(f), 64'h03);
    @(posedge clk); #1;
    chk_regs("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);

    // Release with in_valid=0, then resume.
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk_regs("rst_release", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk); a = 8'h03; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_regs("resume", 8'h01, 1'b1, 1'b0, 1'b0);

    // WIDTH=16 instance.
    @(negedge clk);
    in_valid = 1'b0;
    a16 = 16'hA5A5; b16 = 16'h0FF0; in_valid16 = 1'b1; #1;
    chk("w16.F", 64'(f16), 64'h05A0);
    @(posedge clk); #1;
    chk("w16.F_q", 64'(f_q16), 64'h05A0);
    chk("w16.flags", 64'({out_valid16, zero_q16, ones_q16}), 64'b100);
    @(negedge clk); a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk); #1;
    chk("w16.ones_F_q", 64'(f_q16), 64'hFFFF);
    chk("w16.ones_flags", 64'({out_valid16, zero_q16, ones_q16}), 64'b101);
    @(negedge clk); a16 = 16'h00FF; b16 = 16'hFF00;
    @(posedge clk); #1;
    chk("w16.zero_flags", 64'({out_valid16, zero_q16, ones_q16}), 64'b110);
    @(negedge clk); a16 = 16'h7FFF; b16 = 16'hFFFF;
    @(posedge clk); #1;
    chk("w16.not_ones", 64'({out_valid16, zero_q16, ones_q16}), 64'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/and_unit.md
Name: and_unit

Overview:
- Bitwise AND datapath element for the ALU. F is a purely combinational A & B, with no clock involvement.
- A registered copy with valid and status flags is also provided, for pipelined consumers in the ALU result path.
- Default operand width is 8 bits.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset for all registers.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A/B for the registered path.
- F  output  WIDTH  combinational A & B.
- F_q  output  WIDTH  registered A & B.
- out_valid  output  1  F_q, zero_q and ones_q hold a valid result.
- zero_q  output  1  registered flag: result equals 0.
- ones_q  output  1  registered flag: result is all ones.

Interface rule (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Combinational output F:
  - F[i] = A[i] & B[i] for every bit; zero latency.
  - F is independent of clk, rst and in_valid.
  - F settles within the same delta or timestep as any change on A or B, so sampling 1 ns after an operand change must show the new value.
- Reset:
  - While rst=1, regardless of clk: F_q=0, out_valid=0, zero_q=0, ones_q=0.
  - Assertion takes effect immediately (asynchronous). Deassertion is synchronous in effect: registers resume on the first rising clk edge with rst=0.
  - Reset mid-operation discards any pending result. out_valid drops immediately; F stays live.
- Registered path, 1-cycle latency. On each rising clk edge with rst=0:
  - If in_valid=1: F_q <= A & B; zero_q <= (A & B == 0); ones_q <= (A & B == all ones); out_valid <= 1.
  - If in_valid=0: out_valid <= 0; F_q, zero_q and ones_q hold their previous values.
- Back-to-back operation: in_valid may be high on consecutive cycles; each cycle produces a new result one cycle later. There is no backpressure and no stall input.
- Width rules:
  - No carry, no sign extension; the result width equals WIDTH.
  - ones_q compares against a WIDTH-bit all-ones value.
- X handling: an X on an operand bit propagates only to that bit of F. When the corresponding bit of the other operand is 0, the result bit is 0, per Verilog & semantics.
- Both flags being 1 at once is impossible for WIDTH >= 1.

Test Plan:
- Combinational: A=8'd1, B=8'd1 -> F=8'd1 within 1 ns; A=8'hFF, B=8'h7B -> F=8'h7B; A=8'h87, B=8'h0A -> F=8'h02.
- Registered: in_valid=1 with A=8'hFF, B=8'h7B at edge N -> at edge N+1 F_q=8'h7B, out_valid=1, zero_q=0, ones_q=0. Then in_valid=0 -> out_valid=0 after the next edge, F_q held at 8'h7B.
- Flags: A=8'hF0, B=8'h0F -> zero_q=1, F_q=8'h00. A=8'hFF, B=8'hFF -> ones_q=1, F_q=8'hFF.
- Streaming: in_valid high for 3 cycles with pairs (01,01), (FF,7B), (87,0A) -> F_q sequence 01, 7B, 02 on successive edges, out_valid continuously 1.
- Async reset: assert rst between clock edges while out_valid=1 -> out_valid, F_q and flags go to 0 immediately without a clock edge. F still tracks A & B during reset.
- Parameter: WIDTH=16, A=16'hA5A5, B=16'h0FF0 -> F=16'h05A0; all-ones check uses 16'hFFFF.
